// File: rtl/icache_refill_ctrl_pkg.sv
// Shared widths, state encoding and small helpers for the instruction-cache
// refill controller and its LRU array.
package icache_refill_ctrl_pkg;

    localparam int INDEX_W    = 7;
    localparam int TAG_W      = 20;
    localparam int OFFSET_W   = 3;
    localparam int WAYS       = 2;
    localparam int LINE_WORDS = 8;
    localparam int SETS       = 1 << INDEX_W;

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_REQ   = 3'd2,
        ST_RECV  = 3'd3,
        ST_TAGW  = 3'd4
    } refill_state_t;

    // One-hot write enable for a single way of the 2-way arrays.
    function automatic logic [WAYS-1:0] way_onehot(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/icache_lru.sv
// Per-set LRU bit array: each bit names the victim way of its set.
// Cleared asynchronously; a refill (replace) overrides a hit (touch) on the same set.
module icache_lru
    import icache_refill_ctrl_pkg::*;
#(
    parameter int INDEX_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               victim,
    input  logic               replace_en,
    input  logic [INDEX_W-1:0] replace_index,
    input  logic               replace_way,
    input  logic               touch_en,
    input  logic [INDEX_W-1:0] touch_index,
    input  logic               touch_way
);

    localparam int NSETS = 1 << INDEX_W;

    logic [NSETS-1:0] lru;

    // The replace write comes last so it wins when both target the same set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru <= '0;
        end else begin
            if (touch_en)
                lru[touch_index] <= ~touch_way;
            if (replace_en)
                lru[replace_index] <= ~replace_way;
        end
    end

    assign victim = lru[rd_index];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Refill and flush controller for the 2-way instruction cache: clears the
// directories after reset, then fetches missing lines into the LRU victim way.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int INDEX_W    = icache_refill_ctrl_pkg::INDEX_W,
    parameter int TAG_W      = icache_refill_ctrl_pkg::TAG_W,
    parameter int LINE_WORDS = icache_refill_ctrl_pkg::LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_req,
    input  logic [31:0]                   miss_addr,
    input  logic                          hit_valid,
    input  logic [INDEX_W-1:0]            hit_index,
    input  logic                          hit_way,
    output logic                          busy,
    output logic                          refill_done,
    output logic                          mem_rd_req,
    output logic [31:0]                   mem_rd_addr,
    input  logic                          mem_rd_ack,
    input  logic                          mem_rd_valid,
    input  logic [31:0]                   mem_rd_data,
    input  logic                          mem_rd_last,
    output logic [1:0]                    tagv_wen,
    output logic                          tagv_valid_wdata,
    output logic [INDEX_W-1:0]            tagv_index,
    output logic [TAG_W-1:0]              tagv_tag,
    output logic [1:0]                    data_wen,
    output logic [INDEX_W-1:0]            data_index,
    output logic [$clog2(LINE_WORDS)-1:0] data_offset,
    output logic [31:0]                   data_wdata,
    output logic                          protocol_err
);

    localparam int BEAT_W   = $clog2(LINE_WORDS);
    localparam int LINE_LSB = 32 - TAG_W - INDEX_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    refill_state_t      state, state_next;
    logic [INDEX_W-1:0] fidx;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic               victim_q;
    logic [BEAT_W-1:0]  beat_q;
    logic               beat_fire;
    logic               err_set;
    logic               lru_victim;
    logic               unused_addr_bits;

    logic [INDEX_W-1:0] miss_index;
    logic [TAG_W-1:0]   miss_tag;

    assign miss_index       = miss_addr[LINE_LSB +: INDEX_W];
    assign miss_tag         = miss_addr[LINE_LSB + INDEX_W +: TAG_W];
    assign unused_addr_bits = ^miss_addr[LINE_LSB-1:0];

    assign beat_fire = (state == ST_RECV) && mem_rd_valid;
    assign err_set   = beat_fire && (mem_rd_last != (beat_q == LAST_BEAT));
    assign busy      = (state != ST_IDLE);

    icache_lru #(.INDEX_W(INDEX_W)) u_lru (
        .clk           (clk),
        .rst           (rst),
        .rd_index      (miss_index),
        .victim        (lru_victim),
        .replace_en    (state == ST_TAGW),
        .replace_index (index_q),
        .replace_way   (victim_q),
        .touch_en      (hit_valid && (state != ST_FLUSH)),
        .touch_index   (hit_index),
        .touch_way     (hit_way)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FLUSH;
            fidx  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_FLUSH)
                fidx <= fidx + 1'b1;
        end
    end

    // Miss context is captured once in IDLE and held for the whole refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q        <= '0;
            index_q      <= '0;
            victim_q     <= 1'b0;
            beat_q       <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (state == ST_IDLE && miss_req) begin
                tag_q    <= miss_tag;
                index_q  <= miss_index;
                victim_q <= lru_victim;
            end
            if (state == ST_REQ && mem_rd_ack)
                beat_q <= '0;
            else if (beat_fire)
                beat_q <= beat_q + 1'b1;
            if (err_set)
                protocol_err <= 1'b1;
        end
    end

    always_comb begin
        state_next       = state;
        refill_done      = 1'b0;
        mem_rd_req       = 1'b0;
        mem_rd_addr      = '0;
        tagv_wen         = '0;
        tagv_valid_wdata = 1'b0;
        tagv_index       = '0;
        tagv_tag         = '0;
        data_wen         = '0;
        data_index       = '0;
        data_offset      = '0;
        data_wdata       = '0;

        case (state)
            ST_FLUSH: begin
                tagv_wen   = 2'b11;
                tagv_index = fidx;
                if (fidx == {INDEX_W{1'b1}})
                    state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (miss_req)
                    state_next = ST_REQ;
            end
            ST_REQ: begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = {tag_q, index_q, {LINE_LSB{1'b0}}};
                if (mem_rd_ack)
                    state_next = ST_RECV;
            end
            // The beat counter, not mem_rd_last, decides when the line is complete.
            ST_RECV: begin
                if (mem_rd_valid) begin
                    data_wen    = way_onehot(victim_q);
                    data_index  = index_q;
                    data_offset = beat_q;
                    data_wdata  = mem_rd_data;
                    if (beat_q == LAST_BEAT)
                        state_next = ST_TAGW;
                end
            end
            ST_TAGW: begin
                tagv_wen         = way_onehot(victim_q);
                tagv_valid_wdata = 1'b1;
                tagv_index       = index_q;
                tagv_tag         = tag_q;
                refill_done      = 1'b1;
                state_next       = ST_IDLE;
            end
            default: begin
                state_next = ST_FLUSH;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl: flush sweep, refills,
// LRU victim choice, backpressure, protocol error and reset mid-refill.
module tb_icache_refill_ctrl;

    logic        clk;
    logic        rst;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        hit_valid;
    logic [6:0]  hit_index;
    logic        hit_way;
    logic        busy;
    logic        refill_done;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        mem_rd_last;
    logic [1:0]  tagv_wen;
    logic        tagv_valid_wdata;
    logic [6:0]  tagv_index;
    logic [19:0] tagv_tag;
    logic [1:0]  data_wen;
    logic [6:0]  data_index;
    logic [2:0]  data_offset;
    logic [31:0] data_wdata;
    logic        protocol_err;

    int compared;
    int mismatched;

    icache_refill_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .miss_req         (miss_req),
        .miss_addr        (miss_addr),
        .hit_valid        (hit_valid),
        .hit_index        (hit_index),
        .hit_way          (hit_way),
        .busy             (busy),
        .refill_done      (refill_done),
        .mem_rd_req       (mem_rd_req),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_ack       (mem_rd_ack),
        .mem_rd_valid     (mem_rd_valid),
        .mem_rd_data      (mem_rd_data),
        .mem_rd_last      (mem_rd_last),
        .tagv_wen         (tagv_wen),
        .tagv_valid_wdata (tagv_valid_wdata),
        .tagv_index       (tagv_index),
        .tagv_tag         (tagv_tag),
        .data_wen         (data_wen),
        .data_index       (data_index),
        .data_offset      (data_offset),
        .data_wdata       (data_wdata),
        .protocol_err     (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at the negedge where rst has just been released.
    task automatic checkFlush();
        for (int i = 0; i < 128; i++) begin
            #1;
            checkOutput("flush_busy", 32'(busy), 32'd1);
            checkOutput("flush_wen", 32'(tagv_wen), 32'h3);
            checkOutput("flush_index", 32'(tagv_index), 32'(i));
            checkOutput("flush_valid", 32'(tagv_valid_wdata), 32'd0);
            checkOutput("flush_data_wen", 32'(data_wen), 32'd0);
            @(negedge clk);
        end
        #1;
        checkOutput("flush_end_busy", 32'(busy), 32'd0);
        checkOutput("flush_end_wen", 32'(tagv_wen), 32'd0);
    endtask

    task automatic applyHit(input logic [6:0] idx, input logic way);
        @(negedge clk);
        hit_valid = 1'b1;
        hit_index = idx;
        hit_way   = way;
        @(negedge clk);
        hit_valid = 1'b0;
    endtask

    // Full refill: ack after ack_delay cycles, gap idle cycles before each beat,
    // mem_rd_last on beat last_beat, optional conflicting hit during TAGW.
    task automatic applyStimulus(input logic [31:0] addr, input int ack_delay, input int gap,
                                 input logic exp_way, input int last_beat, input bit hit_tagw);
        logic [6:0]  exp_idx;
        logic [19:0] exp_tag;
        logic [1:0]  exp_wen;
        exp_idx = addr[11:5];
        exp_tag = addr[31:12];
        exp_wen = exp_way ? 2'b10 : 2'b01;

        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = addr;
        #1;
        checkOutput("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        for (int d = 0; d < ack_delay; d++) begin
            #1;
            checkOutput("req_wait", 32'(mem_rd_req), 32'd1);
            checkOutput("req_wait_addr", mem_rd_addr, addr & 32'hFFFF_FFE0);
            @(negedge clk);
        end
        mem_rd_ack = 1'b1;
        #1;
        checkOutput("req", 32'(mem_rd_req), 32'd1);
        checkOutput("req_addr", mem_rd_addr, addr & 32'hFFFF_FFE0);
        @(negedge clk);
        mem_rd_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gap; g++) begin
                mem_rd_valid = 1'b0;
                mem_rd_last  = 1'b0;
                #1;
                checkOutput("gap_data_wen", 32'(data_wen), 32'd0);
                checkOutput("gap_req", 32'(mem_rd_req), 32'd0);
                @(negedge clk);
            end
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hA0 + 32'(k);
            mem_rd_last  = (k == last_beat);
            #1;
            checkOutput("beat_wen", 32'(data_wen), 32'(exp_wen));
            checkOutput("beat_index", 32'(data_index), 32'(exp_idx));
            checkOutput("beat_offset", 32'(data_offset), 32'(k));
            checkOutput("beat_wdata", data_wdata, 32'hA0 + 32'(k));
            @(negedge clk);
        end
        mem_rd_valid = 1'b0;
        mem_rd_last  = 1'b0;
        if (hit_tagw) begin
            hit_valid = 1'b1;
            hit_index = exp_idx;
            hit_way   = ~exp_way;
        end
        #1;
        checkOutput("tagw_wen", 32'(tagv_wen), 32'(exp_wen));
        checkOutput("tagw_valid", 32'(tagv_valid_wdata), 32'd1);
        checkOutput("tagw_index", 32'(tagv_index), 32'(exp_idx));
        checkOutput("tagw_tag", 32'(tagv_tag), 32'(exp_tag));
        checkOutput("tagw_done", 32'(refill_done), 32'd1);
        checkOutput("tagw_data_wen", 32'(data_wen), 32'd0);
        @(negedge clk);
        hit_valid = 1'b0;
        miss_req  = 1'b0;
        #1;
        checkOutput("post_busy", 32'(busy), 32'd0);
        checkOutput("post_done", 32'(refill_done), 32'd0);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        rst          = 1'b1;
        miss_req     = 1'b0;
        miss_addr    = '0;
        hit_valid    = 1'b0;
        hit_index    = '0;
        hit_way      = 1'b0;
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        mem_rd_last  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd1);
        checkOutput("rst_tagv_wen", 32'(tagv_wen), 32'h3);
        checkOutput("rst_tagv_index", 32'(tagv_index), 32'd0);
        checkOutput("rst_valid", 32'(tagv_valid_wdata), 32'd0);
        checkOutput("rst_req", 32'(mem_rd_req), 32'd0);
        checkOutput("rst_done", 32'(refill_done), 32'd0);
        checkOutput("rst_err", 32'(protocol_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkFlush();

        // Basic refill, then victim alternation on set 0x1A.
        applyStimulus(32'h0001_2340, 0, 0, 1'b0, 7, 1'b0);
        checkOutput("basic_err", 32'(protocol_err), 32'd0);
        applyStimulus(32'h0002_2340, 0, 0, 1'b1, 7, 1'b0);
        applyStimulus(32'h0003_2340, 0, 0, 1'b0, 7, 1'b0);

        // Hit on way 1 makes way 0 the victim; a hit during TAGW loses to the refill.
        applyHit(7'h1A, 1'b1);
        applyStimulus(32'h0004_2340, 0, 0, 1'b0, 7, 1'b1);
        applyStimulus(32'h0005_2340, 0, 0, 1'b1, 7, 1'b0);
        applyHit(7'h1A, 1'b0);
        applyStimulus(32'h0006_2340, 0, 0, 1'b1, 7, 1'b0);

        // Backpressure with unaligned miss address on an untouched set.
        applyStimulus(32'hDEAD_BEEC, 3, 2, 1'b0, 7, 1'b0);
        checkOutput("bp_err", 32'(protocol_err), 32'd0);

        // Early mem_rd_last on the fifth beat.
        applyStimulus(32'h0000_0040, 0, 0, 1'b0, 4, 1'b0);
        checkOutput("perr_set", 32'(protocol_err), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("perr_held", 32'(protocol_err), 32'd1);

        // Reset after four beats of a way-1 refill on set 0x1A.
        applyHit(7'h1A, 1'b0);
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = 32'h0007_2340;
        @(negedge clk);
        mem_rd_ack = 1'b1;
        #1;
        checkOutput("mid_req", 32'(mem_rd_req), 32'd1);
        @(negedge clk);
        mem_rd_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'h50 + 32'(k);
            #1;
            checkOutput("mid_beat_wen", 32'(data_wen), 32'h2);
            @(negedge clk);
        end
        mem_rd_data = 32'h54;
        #1;
        checkOutput("mid_err_before", 32'(protocol_err), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd1);
        checkOutput("mid_rst_req", 32'(mem_rd_req), 32'd0);
        checkOutput("mid_rst_wen", 32'(tagv_wen), 32'h3);
        checkOutput("mid_rst_index", 32'(tagv_index), 32'd0);
        checkOutput("mid_rst_data_wen", 32'(data_wen), 32'd0);
        checkOutput("mid_rst_err", 32'(protocol_err), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        miss_req = 1'b0;
        checkFlush();
        mem_rd_valid = 1'b0;

        // LRU was cleared by reset, so set 0x1A picks way 0 again.
        applyStimulus(32'h0008_2340, 0, 1, 1'b0, 7, 1'b0);
        checkOutput("final_err", 32'(protocol_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
